// File: rtl/io_master.sv
// Single-outstanding bridge from a core load/store port to a one-cycle I/O bus.
// Partial stores are carried out as read-modify-write; out-of-window requests are answered without a bus cycle.
module io_master #(
   parameter logic [23:0] IO_BASE = 24'h800000
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [7:0]  io_addr,
   output logic        io_en,
   output logic        io_we,
   output logic [31:0] io_data_write,
   input  logic [31:0] io_data_read,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        err_q, err_d;
   logic [31:0] merged;
   logic        unused_addr_lsb;

   // Byte lanes come from the address through req_be, so the low address bits carry nothing.
   assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

   always_comb begin
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : io_data_read[8*i +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               be_d    = req_be;
               wdata_d = req_wdata;
               if ((req_addr[31:8] != IO_BASE) || (req_we && (req_be == 4'h0))) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  // io_addr only moves for requests that will actually use the bus.
                  err_d  = 1'b0;
                  addr_d = {req_addr[7:2], 2'b00};
                  if (req_we && (req_be == 4'hF)) begin
                     wr_data_d = req_wdata;
                     state_d   = S_WR;
                  end else begin
                     state_d = S_RD;
                  end
               end
            end
         end
         S_RD: begin
            rdata_d = io_data_read;
            if (we_q) begin
               wr_data_d = merged;
               state_d   = S_WR;
            end else begin
               state_d = S_RESP;
            end
         end
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   // Bus strobes decode from state alone, so reset drops them without a clock.
   assign req_ready     = (state_q == S_IDLE);
   assign io_en         = (state_q == S_RD) || (state_q == S_WR);
   assign io_we         = (state_q == S_WR);
   assign io_addr       = addr_q;
   assign io_data_write = wr_data_q;
   assign rsp_valid     = (state_q == S_RESP);
   assign rsp_err       = (state_q == S_RESP) && err_q;
   assign rsp_rdata     = ((state_q == S_RESP) && !we_q && !err_q) ? rdata_q : 32'h0;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_io_master.sv
// Bench for io_master: a word-array responder on the I/O bus, directed scenarios with
// cycle-exact bus checks, and a response scoreboard fed from a reference memory.
module tb_io_master;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        req_we = 1'b0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  io_addr;
   logic        io_en;
   logic        io_we;
   logic [31:0] io_data_write;
   logic [31:0] io_data_read;
   logic [1:0]  dbg_state;

   io_master dut (
      .clk(clk), .resetb(resetb),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
      .io_data_write(io_data_write), .io_data_read(io_data_read),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic [32:0] exp_q [$];
   logic [32:0] mon_exp;
   int checks = 0;
   int failures = 0;
   int io_en_cnt = 0;

   assign io_data_read = mem[io_addr[7:2]];

   always @(posedge clk) begin
      if (io_en && io_we) mem[io_addr[7:2]] <= io_data_write;
   end

   // Response scoreboard: {err, rdata} in request order.
   always @(negedge clk) begin
      if (io_en) io_en_cnt++;
      if (rsp_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected got err=%0b rdata=%h required no response", rsp_err, rsp_rdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({rsp_err, rsp_rdata} !== mon_exp) begin
               failures++;
               $display("FAIL rsp_data got err=%0b rdata=%h required err=%0b rdata=%h",
                        rsp_err, rsp_rdata, mon_exp[32], mon_exp[31:0]);
            end
         end
      end
   end

   task automatic model(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output logic [32:0] e, output int lat);
      logic [5:0] idx;
      idx = a[7:2];
      if ((a[31:8] != 24'h800000) || (w && (b == 4'h0))) begin
         e = {1'b1, 32'h0};
         lat = 1;
      end else if (!w) begin
         e = {1'b0, ref_mem[idx]};
         lat = 2;
      end else begin
         for (int i = 0; i < 4; i++) if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
         e = 33'h0;
         lat = (b == 4'hF) ? 3'd2 : 3'd3;
      end
   endtask

   // Drives one request, returns just after the accepting edge (cycle T+1 begins).
   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int lat, output time t_acc, output bit ok);
      logic [32:0] e;
      int budget;
      model(a, w, b, d, e, lat);
      exp_q.push_back(e);
      req_valid = 1'b1; req_addr = a; req_we = w; req_be = b; req_wdata = d;
      ok = 1'b1;
      t_acc = 0;
      budget = 0;
      @(negedge clk);
      while (!req_ready && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      if (!req_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout req_ready=%0b required=1", req_ready);
         req_valid = 1'b0;
         void'(exp_q.pop_back());
         ok = 1'b0;
         return;
      end
      @(posedge clk);
      t_acc = $time;
      #1;
      // Scramble the request bus so anything not latched at accept would show.
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_we    = 1'($urandom_range(0, 1));
      req_be    = 4'($urandom_range(0, 15));
      req_wdata = $urandom;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || io_en !== 1'b0 || io_we !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl got ready=%0b en=%0b we=%0b rv=%0b err=%0b required 1 0 0 0 0",
                  req_ready, io_en, io_we, rsp_valid, rsp_err);
      end
      checks++;
      if (io_addr !== 8'h0 || io_data_write !== 32'h0 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_data got addr=%h wd=%h rd=%h required 0 0 0", io_addr, io_data_write, rsp_rdata);
      end
      @(posedge clk);
      #1 resetb = 1'b1;
   endtask

   task automatic test_load();
      int lat; time t; bit ok;
      mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
      issue(32'h80000014, 1'b0, 4'h0, 32'h0, lat, t, ok);
      if (!ok) return;
      @(negedge clk);
      checks++;
      if (io_en !== 1'b1 || io_we !== 1'b0 || io_addr !== 8'h14 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL load_t1 got en=%0b we=%0b addr=%h ready=%0b required 1 0 14 0", io_en, io_we, io_addr, req_ready);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || io_en !== 1'b0) begin
         failures++;
         $display("FAIL load_t2 got rv=%0b en=%0b required 1 0", rsp_valid, io_en);
      end
   endtask

   task automatic test_full_store();
      int lat; time t; bit ok;
      mem[4] = 32'h0; ref_mem[4] = 32'h0;
      issue(32'h80000010, 1'b1, 4'hF, 32'h12345678, lat, t, ok);
      if (!ok) return;
      @(negedge clk);
      checks++;
      if (io_en !== 1'b1 || io_we !== 1'b1 || io_addr !== 8'h10 || io_data_write !== 32'h12345678) begin
         failures++;
         $display("FAIL fstore_t1 got en=%0b we=%0b addr=%h wd=%h required 1 1 10 12345678", io_en, io_we, io_addr, io_data_write);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || io_en !== 1'b0 || mem[4] !== 32'h12345678) begin
         failures++;
         $display("FAIL fstore_t2 got rv=%0b err=%0b en=%0b mem=%h required 1 0 0 12345678", rsp_valid, rsp_err, io_en, mem[4]);
      end
   endtask

   task automatic test_partial_store();
      int lat; time t; bit ok;
      mem[6] = 32'h11223344; ref_mem[6] = 32'h11223344;
      issue(32'h80000018, 1'b1, 4'b0010, 32'h0000AB00, lat, t, ok);
      if (!ok) return;
      @(negedge clk);
      checks++;
      if (io_en !== 1'b1 || io_we !== 1'b0 || io_addr !== 8'h18) begin
         failures++;
         $display("FAIL pstore_rd got en=%0b we=%0b addr=%h required 1 0 18", io_en, io_we, io_addr);
      end
      @(negedge clk);
      checks++;
      if (io_en !== 1'b1 || io_we !== 1'b1 || io_data_write !== 32'h1122AB44) begin
         failures++;
         $display("FAIL pstore_wr got en=%0b we=%0b wd=%h required 1 1 1122ab44", io_en, io_we, io_data_write);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || io_en !== 1'b0) begin
         failures++;
         $display("FAIL pstore_rsp got rv=%0b en=%0b required 1 0", rsp_valid, io_en);
      end
   endtask

   task automatic test_errors();
      int lat; time t; bit ok; int c0;
      c0 = io_en_cnt;
      issue(32'h40000000, 1'b0, 4'h0, 32'h0, lat, t, ok);
      if (!ok) return;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || io_en !== 1'b0) begin
         failures++;
         $display("FAIL oow_rsp got rv=%0b err=%0b en=%0b required 1 1 0", rsp_valid, rsp_err, io_en);
      end
      issue(32'h80000020, 1'b1, 4'h0, 32'hFFFFFFFF, lat, t, ok);
      if (!ok) return;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || io_en !== 1'b0) begin
         failures++;
         $display("FAIL be0_rsp got rv=%0b err=%0b en=%0b required 1 1 0", rsp_valid, rsp_err, io_en);
      end
      @(posedge clk);
      checks++;
      if (io_en_cnt !== c0) begin
         failures++;
         $display("FAIL err_no_bus got io_en_cycles=%0d required=%0d", io_en_cnt, c0);
      end
   endtask

   task automatic test_reset_mid();
      int lat; time t; time t_rel; bit ok;
      mem[8] = 32'hA5A5A5A5; ref_mem[8] = 32'hA5A5A5A5;
      issue(32'h80000020, 1'b1, 4'hF, 32'hCAFEF00D, lat, t, ok);
      if (!ok) return;
      @(negedge clk);
      checks++;
      if (io_en !== 1'b1 || io_we !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_wr got en=%0b we=%0b required 1 1", io_en, io_we);
      end
      #2 resetb = 1'b0;
      #1;
      checks++;
      if (io_en !== 1'b0 || io_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async got en=%0b we=%0b ready=%0b rv=%0b required 0 0 1 0", io_en, io_we, req_ready, rsp_valid);
      end
      exp_q.delete();
      ref_mem[8] = 32'hA5A5A5A5;
      repeat (2) @(negedge clk);
      @(posedge clk);
      t_rel = $time;
      #1 resetb = 1'b1;
      issue(32'h80000020, 1'b0, 4'h0, 32'h0, lat, t, ok);
      if (!ok) return;
      checks++;
      if (t !== t_rel + 10) begin
         failures++;
         $display("FAIL rst_first_accept got t=%0t required t=%0t", t, t_rel + 10);
      end
      @(negedge clk);
      checks++;
      if (io_en !== 1'b1 || io_we !== 1'b0 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_load_t1 got en=%0b we=%0b rv=%0b required 1 0 0", io_en, io_we, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_load_t2 got rv=%0b required 1", rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lat, prev_lat; time t, prev_t; bit ok;
      logic [31:0] a;
      logic w;
      logic [3:0] b;
      prev_lat = 0; prev_t = 0;
      for (int i = 0; i < 20; i++) begin
         a = {24'h800000, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 5) == 0) a[31:24] = 8'($urandom_range(0, 127));
         w = 1'($urandom_range(0, 1));
         b = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) b = 4'hF;
         issue(a, w, b, $urandom, lat, t, ok);
         if (!ok) return;
         if (i > 0) begin
            checks++;
            if (t - prev_t !== time'((prev_lat + 1) * 10)) begin
               failures++;
               $display("FAIL b2b_gap req=%0d got gap=%0t required=%0d", i, t - prev_t, (prev_lat + 1) * 10);
            end
         end
         prev_t = t;
         prev_lat = lat;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL b2b_drain got pending=%0d required=0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_load();
      test_full_store();
      test_partial_store();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL final_drain got pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
